// File: rtl/iter_addsub_pkg.sv
// Shared definitions for the chunked iterative adder/subtractor.
//   state_t      : FSM state encoding (IDLE, CALC, DONE)
//   calc_nchunk  : number of CHUNK-bit slices in a WIDTH-bit operand
//   calc_idx_w   : width of the chunk index register (at least 1 bit)
package iter_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/iter_addsub_chunk.sv
// Combinational CHUNK-bit adder slice used once per CALC cycle.
//   i_a, i_b : CHUNK-bit operand slices (i_b already inverted for subtract)
//   i_cin    : carry into the slice
//   o_sum    : CHUNK-bit slice result
//   o_cout   : carry out of the slice MSB
//   o_c_msb  : carry into the slice MSB (used for signed overflow)
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [CHUNK:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum   = w_full[CHUNK-1:0];
  assign o_cout  = w_full[CHUNK];
  // sum_msb = a_msb ^ b_msb ^ carry_in_msb, so the incoming carry is recovered by xor.
  assign o_c_msb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

// File: rtl/iter_addsub.sv
// Iterative WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, carry_in, sub)
//   out_valid/out_ready : result handshake (sum, carry_out, overflow)
//   dbg_state           : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is 1 only in IDLE, out_valid is 1 only in DONE, and the
// result outputs hold stable for as long as out_valid is 1.
// Subtraction is a + ~b + ~borrow_in; carry_out is then the inverted final
// carry so that 1 means borrow.
module iter_addsub
  import iter_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output state_t           dbg_state
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idx_w(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $fatal(1, "iter_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_calc;
  logic              w_last;

  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_sub;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [CHUNK-1:0]  w_op_a;
  logic [CHUNK-1:0]  w_op_b;
  logic [CHUNK-1:0]  w_c_sum;
  logic              w_c_cout;
  logic              w_c_msb;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_calc   = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = CALC;
        end
      end
      CALC: begin
        w_calc = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------- operand slice select ----------------
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_op_a = r_a[i*CHUNK +: CHUNK];
        w_op_b = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .i_cin  (r_carry),
    .o_sum  (w_c_sum),
    .o_cout (w_c_cout),
    .o_c_msb(w_c_msb)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // B and carry are pre-conditioned so CALC is a plain add in both modes.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~carry_in : carry_in;
      r_sub   <= sub;
      r_idx   <= '0;
    end else if (w_calc) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (r_idx == IDXW'(i)) r_sum[i*CHUNK +: CHUNK] <= w_c_sum;
      end
      r_carry <= w_c_cout;
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) begin
        r_cout <= r_sub ^ w_c_cout;
        r_ovf  <= w_c_cout ^ w_c_msb;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_iter_addsub.sv
// Directed testbench for iter_addsub: a 32/8 instance for the main vectors
// and an 8/8 instance for the single-chunk case.
module tb_iter_addsub;
  import iter_addsub_pkg::*;

  localparam int NCH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 32/8 DUT signals ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        carry_in = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  state_t      dbg_state;

  // ---------------- 8/8 DUT signals ----------------
  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [7:0]  n_a = '0;
  logic [7:0]  n_b = '0;
  logic        n_carry_in = 1'b0;
  logic        n_sub = 1'b0;
  logic        n_out_valid;
  logic        n_out_ready = 1'b0;
  logic [7:0]  n_sum;
  logic        n_carry_out;
  logic        n_overflow;
  state_t      n_dbg_state;

  iter_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .dbg_state(dbg_state)
  );

  iter_addsub #(.WIDTH(8), .CHUNK(8)) dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .carry_in(n_carry_in), .sub(n_sub),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .sum(n_sum),
    .carry_out(n_carry_out), .overflow(n_overflow), .dbg_state(n_dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation into the 32-bit DUT; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tci, input logic tsub, input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_v; carry_in = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // out_valid must stay low for NCH-1 edges and rise on edge NCH.
  task automatic wait_result(input string tag);
    for (int i = 1; i < NCH; i++) begin
      @(posedge clk);
      #1 check({tag, " out_valid early"}, 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1 check({tag, " out_valid on time"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] es,
                              input logic ec, input logic eo);
    check({tag, " sum"}, 64'(sum), 64'(es));
    check({tag, " carry_out"}, 64'(carry_out), 64'(ec));
    check({tag, " overflow"}, 64'(overflow), 64'(eo));
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " out_valid after take"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after take"}, 64'(in_ready), 64'd1);
  endtask

  task automatic full_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tci, input logic tsub,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input string tag);
    start_op(ta, tb_v, tci, tsub, tag);
    wait_result(tag);
    check_result(tag, es, ec, eo);
    finish_op(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;

    // ---- reset ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset carry_out", 64'(carry_out), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset n_in_ready", 64'(n_in_ready), 64'd1);

    // out_ready while idle must do nothing
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("idle out_ready out_valid", 64'(out_valid), 64'd0);
    check("idle out_ready in_ready", 64'(in_ready), 64'd1);

    // ---- directed arithmetic vectors ----
    full_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add wrap");
    full_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add ovf");
    full_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0, "sub borrow");
    full_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub ovf");
    full_op(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0, "add ripple");

    // sum holds last result while idle
    @(posedge clk);
    #1 check("idle sum hold", 64'(sum), 64'h0100_0101);

    // ---- backpressure with operand churn ----
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, "stall");
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = 1'b1;
    wait_result("stall");
    check_result("stall", 32'h0001_0000, 1'b0, 1'b0);
    held = 32'h0001_0000;
    for (int i = 0; i < 5; i++) begin
      a = ~a; b = ~b; in_valid = 1'b1; carry_in = ~carry_in;
      @(posedge clk);
      #1;
      check("stall sum stable", 64'(sum), 64'(held));
      check("stall out_valid held", 64'(out_valid), 64'd1);
      check("stall in_ready low", 64'(in_ready), 64'd0);
      check("stall carry_out stable", 64'(carry_out), 64'd0);
    end
    in_valid = 1'b0;
    finish_op("stall");

    // ---- reset in second CALC cycle ----
    start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, "mid rst");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid rst in_ready", 64'(in_ready), 64'd1);
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst sum", 64'(sum), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("mid rst no out_valid", 64'(out_valid), 64'd0);
    end
    full_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post rst");

    // ---- single-chunk instance ----
    @(negedge clk);
    n_a = 8'hFF; n_b = 8'h01; n_carry_in = 1'b1; n_sub = 1'b0; n_in_valid = 1'b1;
    @(posedge clk);
    #1 n_in_valid = 1'b0;
    check("n8 out_valid early", 64'(n_out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("n8 out_valid on time", 64'(n_out_valid), 64'd1);
    check("n8 sum", 64'(n_sum), 64'h01);
    check("n8 carry_out", 64'(n_carry_out), 64'd1);
    check("n8 overflow", 64'(n_overflow), 64'd0);
    n_out_ready = 1'b1;
    @(posedge clk);
    #1 n_out_ready = 1'b0;
    check("n8 in_ready after take", 64'(n_in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
